fetch_stage_2way: RTL

- Two-wide fetch stage sitting directly upstream of the instruction buffer.
- Holds the fetch PC and presents an 8-byte-aligned block address to the I-cache.
- Slices up to two instructions from the returned block, attaches branch-predictor results, and delivers them with the same-cycle fill-credit rule the instruction buffer enforces (ib_nAvai).
- Redirects on branch mispredict, stalls on I-cache miss, and stops after a HALT.

---
 rtl/fetch_stage_2way.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_stage_2way.sv
// Two-wide fetch stage: holds fetch PC, addresses the I-cache, slices up to two instructions per cycle.
// Latency: outputs are combinational from fetch_PC/state and current inputs; fetch_PC advances on the capture edge.
// Backpressure: delivery limited by ib_nAvai credits; zero credits hold the PC without entering MISS.
module fetch_stage_2way #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_INST = 32'h0000_0555
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_pred_wrong,
  input  logic [63:0]      br_target_PC,
  input  logic [1:0]       ib_nAvai,
  input  logic [63:0]      Icache_data,
  input  logic             Icache_valid,
  input  logic [1:0]       bp_pred_taken,
  input  logic [1:0][63:0] bp_pred_NPC,
  output logic [63:0]      proc2Icache_addr,
  output logic [1:0][63:0] if_PC_out,
  output logic [1:0][31:0] if_inst_out,
  output logic [1:0]       if_valid_out,
  output logic [1:0][63:0] if_not_taken_NPC,
  output logic [1:0]       if_pred_taken,
  output logic [1:0][63:0] if_pred_NPC,
  output logic             if_halted
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] MISS   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // Loaded PCs always have bits [1:0] cleared
  localparam logic [63:0] WORD_MASK = ~64'h3;

  logic [1:0]  state;
  logic [63:0] fetch_PC;
  logic [31:0] inst0;
  logic [31:0] inst1;
  logic [1:0]  block_cnt;
  logic [1:0]  n_fetch;
  logic        halt_dlv;
  logic [63:0] next_PC;

  // Slot 0 is the word at fetch_PC; an odd-word PC leaves only the upper word in the block
  assign inst0     = fetch_PC[2] ? Icache_data[63:32] : Icache_data[31:0];
  assign inst1     = Icache_data[63:32];
  assign block_cnt = fetch_PC[2] ? 2'd1 : 2'd2;

  // Number of instructions delivered this cycle, after credit, taken and HALT trims
  always_comb begin
    n_fetch = (ib_nAvai < block_cnt) ? ib_nAvai : block_cnt;
    if (!Icache_valid || (state != FETCH) || br_pred_wrong)
      n_fetch = 2'd0;
    if ((n_fetch != 2'd0) && (bp_pred_taken[0] || (inst0 == HALT_INST)))
      n_fetch = 2'd1;
  end

  // A HALT in either delivered slot stops fetch after this cycle
  assign halt_dlv = ((n_fetch != 2'd0) && (inst0 == HALT_INST)) ||
                    ((n_fetch == 2'd2) && (inst1 == HALT_INST));

  // Next PC follows the prediction of the youngest delivered slot
  always_comb begin
    next_PC = fetch_PC;
    case (n_fetch)
      2'd1:    next_PC = bp_pred_taken[0] ? (bp_pred_NPC[0] & WORD_MASK) : fetch_PC + 64'd4;
      2'd2:    next_PC = bp_pred_taken[1] ? (bp_pred_NPC[1] & WORD_MASK) : fetch_PC + 64'd8;
      default: next_PC = fetch_PC;
    endcase
  end

  // Output slices; invalid slots are zeroed so the buffer never sees stale instructions
  always_comb begin
    proc2Icache_addr    = {fetch_PC[63:3], 3'b000};
    if_PC_out[0]        = fetch_PC;
    if_PC_out[1]        = fetch_PC + 64'd4;
    if_not_taken_NPC[0] = fetch_PC + 64'd4;
    if_not_taken_NPC[1] = fetch_PC + 64'd8;
    if_valid_out        = {n_fetch == 2'd2, n_fetch != 2'd0};
    if_inst_out[0]      = if_valid_out[0] ? inst0 : 32'h0;
    if_inst_out[1]      = if_valid_out[1] ? inst1 : 32'h0;
    if_pred_taken       = bp_pred_taken & if_valid_out;
    if_pred_NPC         = bp_pred_NPC;
    if_halted           = (state == HALTED);
  end

  // PC and state update: reset > mispredict > HALT delivered > miss
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_PC <= RESET_PC;
    end else if (br_pred_wrong) begin
      state    <= FETCH;
      fetch_PC <= br_target_PC & WORD_MASK;
    end else begin
      case (state)
        FETCH: begin
          if (halt_dlv) begin
            state    <= HALTED;
            fetch_PC <= next_PC;
          end else if (!Icache_valid) begin
            state    <= MISS;
          end else begin
            fetch_PC <= next_PC;
          end
        end
        MISS: begin
          // The response cycle is a bubble; delivery resumes from FETCH next cycle
          if (Icache_valid)
            state <= FETCH;
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule
